// File: rtl/fdc_pkg.sv
// Shared constants for the floppy controller host-side blocks: #FF bit map,
// WD register addresses and the motor state encoding.
package fdc_pkg;

  localparam int unsigned SR_DS_LO = 0;
  localparam int unsigned SR_RST   = 2;
  localparam int unsigned SR_HLT   = 3;
  localparam int unsigned SR_SIDE  = 4;
  localparam int unsigned SR_DDEN  = 6;

  localparam logic [1:0] REG_STATUS = 2'b00;
  localparam logic [1:0] REG_DATA   = 2'b11;

  typedef enum logic [1:0] {
    MOTOR_OFF      = 2'b00,
    MOTOR_ON       = 2'b01,
    MOTOR_SPINDOWN = 2'b10
  } motor_state_e;

endpackage

// File: rtl/fdc_motor_timer.sv
// Single-drive motor control: spins up on a head-load request for this drive
// and keeps spinning for HOLD_CYCLES after the request goes away.
module fdc_motor_timer
  import fdc_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 56000000,
  parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic hld_s,
  input  logic sel_me,
  output logic motor,
  output logic motor_nxt_c
);

  motor_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_c;

  assign req_c       = hld_s & sel_me;
  assign motor_nxt_c = (state_d != MOTOR_OFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MOTOR_OFF;
      cnt_q   <= '0;
      motor   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      motor   <= motor_nxt_c;
    end
  end

  // Leaving ON already counts the first spindown cycle, so the motor drops
  // exactly HOLD_CYCLES cycles after the request disappears.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MOTOR_OFF: begin
        if (req_c) begin
          state_d = MOTOR_ON;
          cnt_d   = CNT_W'(HOLD_CYCLES);
        end
      end
      MOTOR_ON: begin
        if (!req_c) begin
          state_d = MOTOR_SPINDOWN;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      MOTOR_SPINDOWN: begin
        if (req_c) begin
          state_d = MOTOR_ON;
          cnt_d   = CNT_W'(HOLD_CYCLES);
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = MOTOR_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MOTOR_OFF;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/fdc_sysreg_ctrl.sv
// Host-side #FF system register, DRQ/INTRQ handshake, read-data mux and
// per-drive motor timers sitting between the Z80 bus decode and the FDC core.
module fdc_sysreg_ctrl
  import fdc_pkg::*;
#(
  parameter int unsigned NUM_DRIVES        = 4,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned MOTOR_HOLD_CYCLES = 56000000,
  parameter int unsigned CNT_W             = $clog2(MOTOR_HOLD_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            d,
  input  logic [1:0]            a_reg,
  input  logic                  iorq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic                  cs_n,
  input  logic                  csff_n,
  input  logic [7:0]            core_dout,
  input  logic                  core_drq,
  input  logic                  core_intrq,
  input  logic                  core_hld,
  output logic [7:0]            dout,
  output logic                  oe_n,
  output logic                  vg_reset_n,
  output logic                  hrdy,
  output logic                  side1_n,
  output logic                  mfm_n,
  output logic                  drq_ack,
  output logic                  intrq_ack,
  output logic [NUM_DRIVES-1:0] ds,
  output logic [NUM_DRIVES-1:0] motor
);

  logic rd_cyc_c, wr_cyc_c, rd_cyc_q, wr_cyc_q, rd_stb_c, wr_stb_c;
  logic sr_wr_c, stat_rd_c, data_acc_c;
  logic [1:0] drv_sel, drv_sel_nxt_c;
  logic [SYNC_STAGES-1:0] drq_sync, intrq_sync, hld_sync;
  logic drq_s, intrq_s, hld_s;
  logic [NUM_DRIVES-1:0] motor_nxt_c, sel_oh_nxt_c;
  logic unused_d_bits;

  assign unused_d_bits = ^{d[7], d[5]};

  // One strobe per I/O cycle: first clk the qualifier is seen high.
  assign rd_cyc_c = ~iorq_n & ~rd_n;
  assign wr_cyc_c = ~iorq_n & ~wr_n;
  assign rd_stb_c = rd_cyc_c & ~rd_cyc_q;
  assign wr_stb_c = wr_cyc_c & ~wr_cyc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cyc_q <= 1'b0;
      wr_cyc_q <= 1'b0;
    end else begin
      rd_cyc_q <= rd_cyc_c;
      wr_cyc_q <= wr_cyc_c;
    end
  end

  assign sr_wr_c       = wr_stb_c & ~csff_n;
  assign drv_sel_nxt_c = sr_wr_c ? d[SR_DS_LO +: 2] : drv_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      drv_sel    <= '0;
      vg_reset_n <= 1'b0;
      hrdy       <= 1'b0;
      side1_n    <= 1'b1;
      mfm_n      <= 1'b0;
    end else if (sr_wr_c) begin
      drv_sel    <= d[SR_DS_LO +: 2];
      vg_reset_n <= d[SR_RST];
      hrdy       <= d[SR_HLT];
      side1_n    <= ~d[SR_SIDE];
      mfm_n      <= d[SR_DDEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drq_sync   <= '0;
      intrq_sync <= '0;
      hld_sync   <= '0;
    end else begin
      drq_sync   <= {drq_sync[SYNC_STAGES-2:0], core_drq};
      intrq_sync <= {intrq_sync[SYNC_STAGES-2:0], core_intrq};
      hld_sync   <= {hld_sync[SYNC_STAGES-2:0], core_hld};
    end
  end

  assign drq_s   = drq_sync[SYNC_STAGES-1];
  assign intrq_s = intrq_sync[SYNC_STAGES-1];
  assign hld_s   = hld_sync[SYNC_STAGES-1];

  assign stat_rd_c  = rd_stb_c & ~cs_n & (a_reg == REG_STATUS);
  assign data_acc_c = (rd_stb_c | wr_stb_c) & ~cs_n & (a_reg == REG_DATA);

  // A pending acknowledge is dropped as soon as the core lowers its request;
  // that clear takes priority over a coincident new access.
  always_ff @(posedge clk) begin
    if (reset || !vg_reset_n) begin
      intrq_ack <= 1'b0;
      drq_ack   <= 1'b0;
    end else begin
      if (intrq_ack && !intrq_s) intrq_ack <= 1'b0;
      else if (stat_rd_c)        intrq_ack <= 1'b1;

      if (drq_ack && !drq_s)     drq_ack <= 1'b0;
      else if (data_acc_c)       drq_ack <= 1'b1;
    end
  end

  always_comb begin
    dout = 8'hFF;
    if (!cs_n && !rd_n)        dout = core_dout;
    else if (!csff_n && !rd_n) dout = {intrq_s, drq_s, 6'b111111};
  end

  assign oe_n = ~(~rd_n & (~cs_n | ~csff_n));

  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_drive
    assign sel_oh_nxt_c[i] = (drv_sel_nxt_c == 2'(i));

    fdc_motor_timer #(
      .HOLD_CYCLES (MOTOR_HOLD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .hld_s       (hld_s),
      .sel_me      (drv_sel == 2'(i)),
      .motor       (motor[i]),
      .motor_nxt_c (motor_nxt_c[i])
    );
  end

  // Registered alongside motor so ds always equals motor gated by the selected drive.
  always_ff @(posedge clk) begin
    if (reset) ds <= '0;
    else       ds <= motor_nxt_c & sel_oh_nxt_c;
  end

endmodule

// File: tb/tb_fdc_sysreg_ctrl.sv
// Directed bench for fdc_sysreg_ctrl: vector tables for the #FF register and
// the read mux, plus hand sequences for handshakes, motor timing and reset.
module tb_fdc_sysreg_ctrl;

  localparam int unsigned NDRV = 3;

  logic            clk, reset;
  logic [7:0]      d, core_dout, dout;
  logic [1:0]      a_reg;
  logic            iorq_n, rd_n, wr_n, cs_n, csff_n;
  logic            core_drq, core_intrq, core_hld;
  logic            oe_n, vg_reset_n, hrdy, side1_n, mfm_n, drq_ack, intrq_ack;
  logic [NDRV-1:0] ds, motor;

  int n_checks = 0;
  int n_errors = 0;

  fdc_sysreg_ctrl #(
    .NUM_DRIVES        (NDRV),
    .SYNC_STAGES       (2),
    .MOTOR_HOLD_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .a_reg      (a_reg),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .cs_n       (cs_n),
    .csff_n     (csff_n),
    .core_dout  (core_dout),
    .core_drq   (core_drq),
    .core_intrq (core_intrq),
    .core_hld   (core_hld),
    .dout       (dout),
    .oe_n       (oe_n),
    .vg_reset_n (vg_reset_n),
    .hrdy       (hrdy),
    .side1_n    (side1_n),
    .mfm_n      (mfm_n),
    .drq_ack    (drq_ack),
    .intrq_ack  (intrq_ack),
    .ds         (ds),
    .motor      (motor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       to_ff;
    logic [7:0] data;
    logic [3:0] exp;   // {vg_reset_n, hrdy, side1_n, mfm_n}
  } sr_vec_t;

  typedef struct {
    logic       drq;
    logic       intrq;
    logic       cs_n;
    logic       csff_n;
    logic       rd_n;
    logic [7:0] cdout;
    logic [7:0] exp_dout;
    logic       exp_oe_n;
  } rd_vec_t;

  sr_vec_t sr_tab[8];
  rd_vec_t rd_tab[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe edge, then one idle edge so the next access is a fresh cycle.
  task automatic io_write(input logic to_ff, input logic [1:0] addr, input logic [7:0] data);
    iorq_n = 1'b0; wr_n = 1'b0; d = data; a_reg = addr;
    if (to_ff) csff_n = 1'b0; else cs_n = 1'b0;
    tick();
    iorq_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1; csff_n = 1'b1;
    tick();
  endtask

  // Strobe edge only; caller checks right after and idles before the next access.
  task automatic io_read(input logic to_ff, input logic [1:0] addr);
    iorq_n = 1'b0; rd_n = 1'b0; a_reg = addr;
    if (to_ff) csff_n = 1'b0; else cs_n = 1'b0;
    tick();
    iorq_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1; csff_n = 1'b1;
  endtask

  logic dropped;

  initial begin
    sr_tab[0] = '{1'b1, 8'h04, 4'b1010};
    sr_tab[1] = '{1'b1, 8'h08, 4'b0110};
    sr_tab[2] = '{1'b1, 8'h10, 4'b0000};
    sr_tab[3] = '{1'b1, 8'h40, 4'b0011};
    sr_tab[4] = '{1'b1, 8'hA0, 4'b0010};
    sr_tab[5] = '{1'b1, 8'hFF, 4'b1101};
    sr_tab[6] = '{1'b1, 8'h00, 4'b0010};
    sr_tab[7] = '{1'b0, 8'hFF, 4'b0010};

    rd_tab[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h7F, 1'b0};
    rd_tab[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hBF, 1'b0};
    rd_tab[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0};
    rd_tab[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h3F, 1'b0};
    rd_tab[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A, 1'b0};
    rd_tab[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 8'h12, 1'b0};
    rd_tab[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 8'hFF, 1'b1};
    rd_tab[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 8'hFF, 1'b1};
    rd_tab[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1};

    reset = 1'b1; d = 8'h00; a_reg = 2'b00; core_dout = 8'h00;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1; csff_n = 1'b1;
    core_drq = 1'b0; core_intrq = 1'b0; core_hld = 1'b0;
    repeat (3) tick();

    check("reset_sysreg", 32'({vg_reset_n, hrdy, side1_n, mfm_n}), 32'h2);
    check("reset_motor_ds", 32'({motor, ds}), 0);
    check("reset_acks", 32'({drq_ack, intrq_ack}), 0);
    check("reset_bus", 32'({dout, oe_n}), 32'h1FF);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      io_write(sr_tab[i].to_ff, 2'b00, sr_tab[i].data);
      check($sformatf("sysreg_vec%0d", i), 32'({vg_reset_n, hrdy, side1_n, mfm_n}), 32'(sr_tab[i].exp));
    end
    check("sysreg_no_motor", 32'({motor, ds}), 0);

    // #FF = 5D with head load: drive 1 spins up after the synchroniser delay.
    core_hld = 1'b1;
    io_write(1'b1, 2'b00, 8'h5D);
    check("t1_sysreg", 32'({vg_reset_n, hrdy, side1_n, mfm_n}), 32'hD);
    check("t1_motor_early", 32'(motor), 0);
    tick();
    check("t1_motor", 32'(motor), 32'h2);
    check("t1_ds", 32'(ds), 32'h2);

    // Status read acknowledge and its release.
    core_intrq = 1'b1;
    repeat (3) tick();
    io_read(1'b0, 2'b00);
    check("intrq_set", 32'(intrq_ack), 1);
    check("intrq_no_drq", 32'(drq_ack), 0);
    tick();
    check("intrq_hold", 32'(intrq_ack), 1);
    core_intrq = 1'b0;
    repeat (2) tick();
    check("intrq_lat2", 32'(intrq_ack), 1);
    tick();
    check("intrq_clr", 32'(intrq_ack), 0);

    for (int i = 0; i < 9; i++) begin
      core_drq = rd_tab[i].drq; core_intrq = rd_tab[i].intrq;
      repeat (3) tick();
      cs_n = rd_tab[i].cs_n; csff_n = rd_tab[i].csff_n; rd_n = rd_tab[i].rd_n;
      core_dout = rd_tab[i].cdout;
      #1;
      check($sformatf("rdmux_vec%0d", i), 32'({dout, oe_n}),
            32'({rd_tab[i].exp_dout, rd_tab[i].exp_oe_n}));
      cs_n = 1'b1; csff_n = 1'b1; rd_n = 1'b1;
    end
    core_drq = 1'b0; core_intrq = 1'b0;
    tick();

    // Spindown: motor falls 16 cycles after hld_s (18 after core_hld).
    core_hld = 1'b0;
    repeat (17) tick();
    check("spin_hold", 32'(motor), 32'h2);
    tick();
    check("spin_off", 32'(motor), 0);
    core_hld = 1'b1;
    repeat (3) tick();
    check("spin_restart", 32'(motor), 32'h2);

    core_hld = 1'b0;
    repeat (13) tick();
    core_hld = 1'b1;
    dropped = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!motor[1]) dropped = 1'b1;
    end
    check("reload_keep", 32'(dropped), 0);
    core_hld = 1'b0;
    repeat (17) tick();
    check("reload_hold", 32'(motor), 32'h2);
    tick();
    check("reload_off", 32'(motor), 0);
    core_hld = 1'b1;
    repeat (3) tick();
    check("reload_restart", 32'(motor), 32'h2);

    // Drive hand-over: previously selected drives keep spinning unselected.
    io_write(1'b1, 2'b00, 8'h0C);
    check("sel0_motor", 32'(motor), 32'h3);
    check("sel0_ds", 32'(ds), 32'h1);
    io_write(1'b1, 2'b00, 8'h0E);
    check("sel2_motor", 32'(motor), 32'h7);
    check("sel2_ds", 32'(ds), 32'h4);
    io_write(1'b1, 2'b00, 8'h0F);
    check("sel3_motor", 32'(motor), 32'h7);
    check("sel3_ds", 32'(ds), 0);
    repeat (20) tick();
    check("sel3_all_off", 32'(motor), 0);

    // Long data-port write: one strobe only, ack does not re-arm.
    core_drq = 1'b1;
    repeat (3) tick();
    iorq_n = 1'b0; wr_n = 1'b0; cs_n = 1'b0; a_reg = 2'b11; d = 8'h00;
    tick();
    check("drq_set_wr", 32'(drq_ack), 1);
    core_drq = 1'b0;
    repeat (5) tick();
    check("drq_single_stb", 32'(drq_ack), 0);
    iorq_n = 1'b1; wr_n = 1'b1; cs_n = 1'b1;
    tick();

    // Clear wins over a coincident data read strobe.
    core_drq = 1'b1;
    repeat (3) tick();
    io_read(1'b0, 2'b11);
    check("drq_set_rd", 32'(drq_ack), 1);
    core_drq = 1'b0;
    repeat (2) tick();
    check("drq_pre", 32'(drq_ack), 1);
    io_read(1'b0, 2'b11);
    check("drq_clear_wins", 32'(drq_ack), 0);
    tick();

    // Core held in reset: status read cannot raise intrq_ack.
    core_intrq = 1'b1;
    io_write(1'b1, 2'b00, 8'h00);
    repeat (3) tick();
    io_read(1'b0, 2'b00);
    check("ack_forced", 32'(intrq_ack), 0);
    tick();
    core_intrq = 1'b0;

    // Reset during spindown, with a #FF write on the same edge.
    io_write(1'b1, 2'b00, 8'h0C);
    check("rst_pre", 32'(motor), 32'h1);
    core_hld = 1'b0;
    repeat (5) tick();
    check("rst_spinning", 32'(motor), 32'h1);
    reset = 1'b1;
    iorq_n = 1'b0; wr_n = 1'b0; csff_n = 1'b0; d = 8'hFF;
    tick();
    check("rst_motor_ds", 32'({motor, ds}), 0);
    check("rst_sysreg", 32'({vg_reset_n, hrdy, side1_n, mfm_n}), 32'h2);
    iorq_n = 1'b1; wr_n = 1'b1; csff_n = 1'b1;
    reset = 1'b0;
    repeat (3) tick();
    check("rst_stays_off", 32'(motor), 0);
    check("rst_no_write", 32'({vg_reset_n, hrdy, side1_n, mfm_n}), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
